// File: rtl/alu_entry_pkg.sv
// Types and helpers for the switch/button operand entry front end.
package alu_entry_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    SHOW     = 2'd3
  } entry_state_t;

  localparam int FIELD_W    = 32;
  localparam int DIGIT_W    = 4;
  localparam int COUNT_W    = 4;
  localparam int MAX_DIGITS = FIELD_W / DIGIT_W;

  // Shift one hex digit into the low end of a field; the top digit falls off.
  function automatic logic [FIELD_W-1:0] shift_digit(input logic [FIELD_W-1:0] field,
                                                     input logic [DIGIT_W-1:0] digit);
    return {field[FIELD_W-DIGIT_W-1:0], digit};
  endfunction

  // Digit counter that sticks once the field is full.
  function automatic logic [COUNT_W-1:0] bump_count(input logic [COUNT_W-1:0] count);
    if (count >= COUNT_W'(MAX_DIGITS)) return COUNT_W'(MAX_DIGITS);
    return count + COUNT_W'(1);
  endfunction

  // Circular walk through the entry states on a "next" press.
  function automatic entry_state_t advance(input entry_state_t state);
    unique case (state)
      ENTER_A:  return ENTER_B;
      ENTER_B:  return ENTER_OP;
      ENTER_OP: return SHOW;
      default:  return ENTER_A;
    endcase
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types. aluop_t is the operation code consumed by the ALU.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOR   = 4'h5,
    ALU_SLL   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_SRA   = 4'h8,
    ALU_SLT   = 4'h9,
    ALU_SLTU  = 4'hA,
    ALU_LUI   = 4'hB,
    ALU_PASSA = 4'hC,
    ALU_PASSB = 4'hD,
    ALU_MUL   = 4'hE,
    ALU_NOP   = 4'hF
  } aluop_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizer + debouncer + press detector for one active-low push button.
// press is a one-cycle pulse on the debounced high-to-low transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Count consecutive synchronized samples that disagree with the debounced level.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  // Two-flop synchronizer and debounce state; reset reads as "released".
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Front panel operand entry: three debounced buttons drive a small FSM that
// builds operand A, operand B and an ALU op from a hex switch bank.
module alu_operand_entry
  import alu_entry_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic [DIGIT_W-1:0]  sw_digit,
  input  logic                key_shift_n,
  input  logic                key_next_n,
  input  logic                key_clear_n,
  output logic [FIELD_W-1:0]  porta,
  output logic [FIELD_W-1:0]  portb,
  output logic [3:0]          aluop,
  output logic [1:0]          entry_state,
  output logic [COUNT_W-1:0]  digit_count,
  output logic                exec
);

  logic shift_ev, next_ev, clear_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shift (
    .clk(CLOCK_50), .rst(RST), .key_n(key_shift_n), .press(shift_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(CLOCK_50), .rst(RST), .key_n(key_next_n), .press(next_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(CLOCK_50), .rst(RST), .key_n(key_clear_n), .press(clear_ev)
  );

  entry_state_t       state_q, state_d;
  logic [FIELD_W-1:0] a_q, a_d;
  logic [FIELD_W-1:0] b_q, b_d;
  aluop_t             op_q, op_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               exec_q, exec_d;

  // Next-state and field updates; clear beats next beats shift, losers are dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    count_d = count_q;
    exec_d  = 1'b0;

    if (clear_ev) begin
      count_d = '0;
      unique case (state_q)
        ENTER_A:  a_d  = '0;
        ENTER_B:  b_d  = '0;
        ENTER_OP: op_d = ALU_ADD;
        SHOW: begin
          a_d     = '0;
          b_d     = '0;
          op_d    = ALU_ADD;
          state_d = ENTER_A;
        end
      endcase
    end else if (next_ev) begin
      state_d = advance(state_q);
      count_d = '0;
      exec_d  = (state_q == ENTER_OP);
    end else if (shift_ev) begin
      unique case (state_q)
        ENTER_A: begin
          a_d     = shift_digit(a_q, sw_digit);
          count_d = bump_count(count_q);
        end
        ENTER_B: begin
          b_d     = shift_digit(b_q, sw_digit);
          count_d = bump_count(count_q);
        end
        ENTER_OP: begin
          op_d    = aluop_t'(sw_digit);
          count_d = COUNT_W'(1);
        end
        SHOW: ;
      endcase
    end
  end

  // Entry registers; synchronous reset abandons any partial entry.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      count_q <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      count_q <= count_d;
      exec_q  <= exec_d;
    end
  end

  assign porta       = a_q;
  assign portb       = b_q;
  assign aluop       = op_q;
  assign entry_state = state_q;
  assign digit_count = count_q;
  assign exec        = exec_q;

endmodule
